timer_run_controller: RTL and testbench

//  Front-end sequencer for the MM:SS timer datapath. It debounces the raw user buttons and

---
 rtl/timer_run_controller.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_timer_run_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_run_controller.sv
// ---------------------------------------------------------------------------
// timer_run_controller
//   Front-end sequencer for the MM:SS timer datapath. Debounces the five raw
//   user buttons, generates the count strobe (one per CLK_HZ/TICK_HZ cycles
//   while running) and owns the IDLE/SET/RUN/PAUSE/DONE control flow.
//
//   Optional feature (compile-time macro): TIMER_AUTOREPEAT_EN
//     defined   -> a held inc button repeats its pulse every REPEAT_CYCLES
//                  while in IDLE/SET/PAUSE
//     undefined -> one inc pulse per press, REPEAT_CYCLES unused
//
// Ports
//   CLK_50MHZ     in   system clock
//   reset         in   asynchronous active-high reset
//   btn_start     in   raw button (async, active-high)
//   btn_stop      in   raw button
//   btn_delete    in   raw button
//   btn_inc_sec   in   raw button
//   btn_inc_min   in   raw button
//   time_is_zero  in   counter reads 00:00
//   finish        in   counter hit terminal value (level)
//   enableCounter out  one-cycle count strobe
//   forward       out  1 = count up, 0 = count down
//   resetTimer    out  one-cycle clear pulse
//   inc_sec_pulse out  one-cycle seconds-increment request
//   inc_min_pulse out  one-cycle minutes-increment request
//   blank         out  display digits suppressed
//   alarm         out  high while in DONE
//   state         out  [2:0] current state (debug)
// ---------------------------------------------------------------------------
module timer_run_controller #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BLINK_TICKS     = 1,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic       CLK_50MHZ,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_delete,
  input  logic       btn_inc_sec,
  input  logic       btn_inc_min,
  input  logic       time_is_zero,
  input  logic       finish,
  output logic       enableCounter,
  output logic       forward,
  output logic       resetTimer,
  output logic       inc_sec_pulse,
  output logic       inc_min_pulse,
  output logic       blank,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int NBTN = 5;
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = $clog2(DIV);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // button index map
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_DEL   = 2;
  localparam int B_SEC   = 3;
  localparam int B_MIN   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_SET   = 3'b001,
    S_RUN   = 3'b010,
    S_PAUSE = 3'b011,
    S_DONE  = 3'b100
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronise + debounce
  // -------------------------------------------------------------------------
  logic [NBTN-1:0]         raw;
  logic [NBTN-1:0]         s1_q, s2_q;
  logic [NBTN-1:0]         db_q, db_d;
  logic [NBTN-1:0]         ev_q, ev_d;
  logic [NBTN-1:0][DW-1:0] dcnt_q, dcnt_d;
  logic [NBTN-1:0]         rep;

  assign raw = {btn_inc_min, btn_inc_sec, btn_delete, btn_stop, btn_start};

  // The stability counter runs only while the synchronised level differs
  // from the accepted level; the Dth consecutive differing sample flips it.
  always_comb begin
    db_d   = db_q;
    dcnt_d = dcnt_q;
    ev_d   = rep;
    for (int b = 0; b < NBTN; b++) begin
      if (s2_q[b] != db_q[b]) begin
        if (dcnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[b]   = s2_q[b];
          dcnt_d[b] = '0;
          ev_d[b]   = ev_d[b] | s2_q[b];   // rising edge only
        end else begin
          dcnt_d[b] = dcnt_q[b] + 1'b1;
        end
      end else begin
        dcnt_d[b] = '0;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      dcnt_q <= '0;
      ev_q   <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
      ev_q   <= ev_d;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM, prescaler, blink
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            fwd_q, fwd_d;
  logic            en_q, en_d;
  logic            rt_q, rt_d;
  logic            isec_q, isec_d;
  logic            imin_q, imin_d;
  logic            blank_q, blank_d;
  logic            alarm_q, alarm_d;
  logic            tick;

  assign tick = (presc_q == PW'(DIV - 1));

`ifdef TIMER_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [1:0][RW-1:0] rcnt_q, rcnt_d;
  logic               rep_ok;

  // Repeat counter starts at the accepted press and restarts on release or
  // when the FSM leaves the states that accept inc requests.
  always_comb begin
    rep    = '0;
    rcnt_d = rcnt_q;
    rep_ok = (state_q == S_IDLE) || (state_q == S_SET) || (state_q == S_PAUSE);
    for (int i = 0; i < 2; i++) begin
      if (db_q[B_SEC + i] && rep_ok) begin
        if (rcnt_q[i] == RW'(REPEAT_CYCLES - 1)) begin
          rep[B_SEC + i] = 1'b1;
          rcnt_d[i]      = '0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end else begin
        rcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) rcnt_q <= '0;
    else       rcnt_q <= rcnt_d;
  end
`else
  assign rep = '0;
`endif

  // Each branch acts on at most one event, tested in priority order; lower
  // events in the same cycle are dropped.
  always_comb begin
    state_d = state_q;
    fwd_d   = fwd_q;
    en_d    = 1'b0;
    rt_d    = 1'b0;
    isec_d  = 1'b0;
    imin_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev_q[B_START]) begin
          state_d = S_RUN;
          fwd_d   = time_is_zero;
        end else if (ev_q[B_MIN]) begin
          state_d = S_SET;
          imin_d  = 1'b1;
        end else if (ev_q[B_SEC]) begin
          state_d = S_SET;
          isec_d  = 1'b1;
        end
      end
      S_SET: begin
        if (ev_q[B_DEL]) begin
          state_d = S_IDLE;
          rt_d    = 1'b1;
        end else if (ev_q[B_START]) begin
          state_d = S_RUN;
          fwd_d   = time_is_zero;
        end else if (ev_q[B_MIN]) begin
          imin_d  = 1'b1;
        end else if (ev_q[B_SEC]) begin
          isec_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (finish) begin
          state_d = S_DONE;
        end else if (ev_q[B_DEL]) begin
          state_d = S_IDLE;
          rt_d    = 1'b1;
        end else if (ev_q[B_STOP]) begin
          state_d = S_PAUSE;
        end else begin
          en_d    = tick;
        end
      end
      S_PAUSE: begin
        if (ev_q[B_DEL]) begin
          state_d = S_IDLE;
          rt_d    = 1'b1;
        end else if (ev_q[B_START]) begin
          state_d = S_RUN;                 // direction kept
        end else if (ev_q[B_MIN]) begin
          state_d = S_SET;
          imin_d  = 1'b1;
        end else if (ev_q[B_SEC]) begin
          state_d = S_SET;
          isec_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (ev_q[B_DEL] || ev_q[B_STOP] || ev_q[B_START]) begin
          state_d = S_IDLE;
          rt_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler: free-runs in RUN and DONE, holds in PAUSE (so a resumed run
  // keeps its partial second), restarts from 0 on entry to DONE so the blink
  // period is aligned to the alarm.
  always_comb begin
    presc_d = presc_q;
    if ((state_d == S_IDLE) || (state_d == S_SET) ||
        ((state_d == S_DONE) && (state_q != S_DONE))) begin
      presc_d = '0;
    end else if ((state_q == S_RUN) || (state_q == S_DONE)) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    blank_d = blank_q;
    bcnt_d  = bcnt_q;
    alarm_d = (state_d == S_DONE);
    if ((state_q != S_DONE) || (state_d != S_DONE)) begin
      blank_d = 1'b0;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        blank_d = ~blank_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      bcnt_q  <= '0;
      fwd_q   <= 1'b0;
      en_q    <= 1'b0;
      rt_q    <= 1'b0;
      isec_q  <= 1'b0;
      imin_q  <= 1'b0;
      blank_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      fwd_q   <= fwd_d;
      en_q    <= en_d;
      rt_q    <= rt_d;
      isec_q  <= isec_d;
      imin_q  <= imin_d;
      blank_q <= blank_d;
      alarm_q <= alarm_d;
    end
  end

  assign enableCounter = en_q;
  assign forward       = fwd_q;
  assign resetTimer    = rt_q;
  assign inc_sec_pulse = isec_q;
  assign inc_min_pulse = imin_q;
  assign blank         = blank_q;
  assign alarm         = alarm_q;
  assign state         = state_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// ---------------------------------------------------------------------------
// tb_timer_run_controller
//   Directed scenarios with hand-computed expectations, then randomized button
//   traffic. A behavioural model of the controller runs alongside and every
//   cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_timer_run_controller;

  localparam int N = 10;   // CLK_HZ / TICK_HZ
  localparam int D = 4;    // debounce samples
  localparam int B = 1;    // blink ticks
  localparam int R = 8;    // repeat period
  localparam int IDLE = 0, SET = 1, RUN = 2, PAUSE = 3, DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;    // {inc_min, inc_sec, delete, stop, start}
  logic       tiz = 1'b0;
  logic       fin = 1'b0;
  logic       en, fwd, rt, isec, imin, blk, alm;
  logic [2:0] st;

  timer_run_controller #(
    .CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(D), .BLINK_TICKS(B), .REPEAT_CYCLES(R)
  ) dut (
    .CLK_50MHZ(clk), .reset(rst),
    .btn_start(btn[0]), .btn_stop(btn[1]), .btn_delete(btn[2]),
    .btn_inc_sec(btn[3]), .btn_inc_min(btn[4]),
    .time_is_zero(tiz), .finish(fin),
    .enableCounter(en), .forward(fwd), .resetTimer(rt),
    .inc_sec_pulse(isec), .inc_min_pulse(imin),
    .blank(blk), .alarm(alm), .state(st)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ------------------------------------------------------------ model ----
  int       m_st, m_p, m_dt;
  bit       m_fwd, m_en, m_rt, m_is, m_im, m_bl, m_al;
  bit [4:0] m_ev, m_db, r0, r1;
  bit [4:0] win [D];       // last D synchronised samples, newest last
  int       m_held [5];

  function automatic int next_of(int s, int k);
    case (k)
      0: return (s == RUN) ? DONE : -1;                          // finish
      1: return (s != IDLE) ? IDLE : -1;                         // delete
      2: return (s == RUN) ? PAUSE : ((s == DONE) ? IDLE : -1);  // stop
      3: return (s == DONE) ? IDLE : ((s == RUN) ? -1 : RUN);    // start
      default: return (s == IDLE || s == SET || s == PAUSE) ? SET : -1; // inc
    endcase
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_p = 0; m_dt = 0;
    {m_fwd, m_en, m_rt, m_is, m_im, m_bl, m_al} = '0;
    m_ev = '0; m_db = '0; r0 = '0; r1 = '0;
    for (int i = 0; i < D; i++) win[i] = '0;
    for (int i = 0; i < 5; i++) m_held[i] = 0;
  endtask

  task automatic model_step();
    int os, ns, sel;
    bit tick, act, same;
    bit [4:0] syn, nev, rep;
    bit [5:0] evs;
    os   = m_st;
    tick = (os == RUN || os == DONE) && (m_p == N - 1);
    evs  = {m_ev[3], m_ev[4], m_ev[0], m_ev[1], m_ev[2], fin};  // bit k = priority k
    ns = os; sel = -1;
    for (int k = 0; k < 6; k++) begin
      act = evs[k];
      if (sel < 0 && act && next_of(os, k) >= 0) begin
        sel = k; ns = next_of(os, k);
      end
    end
    m_rt = (sel >= 0) && (ns == IDLE);
    m_im = (sel == 4);
    m_is = (sel == 5);
    if (ns == RUN && (os == IDLE || os == SET)) m_fwd = tiz;
    m_en = (os == RUN) && (ns == RUN) && tick;
    if (ns == IDLE || ns == SET || (ns == DONE && os != DONE)) m_p = 0;
    else if (os == RUN || os == DONE) m_p = (m_p + 1) % N;
    if (os == DONE && ns == DONE) begin
      if (tick) m_dt++;
    end else m_dt = 0;
    m_bl = (ns == DONE) && (((m_dt / B) % 2) == 1);
    m_al = (ns == DONE);
    m_st = ns;
    rep = '0;
`ifdef TIMER_AUTOREPEAT_EN
    for (int b = 3; b < 5; b++) begin
      if (m_db[b] && (os == IDLE || os == SET || os == PAUSE)) begin
        m_held[b]++;
        if (m_held[b] == R) begin rep[b] = 1'b1; m_held[b] = 0; end
      end else m_held[b] = 0;
    end
`endif
    // two-stage synchroniser then a D-sample agreement window
    syn = r1; r1 = r0; r0 = btn;
    for (int i = 0; i < D - 1; i++) win[i] = win[i + 1];
    win[D - 1] = syn;
    nev = '0;
    for (int b = 0; b < 5; b++) begin
      same = 1'b1;
      for (int i = 0; i < D; i++) if (win[i][b] != syn[b]) same = 1'b0;
      if (same && syn[b] != m_db[b]) begin
        m_db[b] = syn[b];
        nev[b]  = syn[b];
      end
    end
    m_ev = nev | rep;
  endtask

  initial model_reset();
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ------------------------------------------------- per-cycle compare ----
  int n_sec = 0;
  always @(negedge clk) begin
    logic [9:0] got, exp;
    got = {st, en, fwd, rt, isec, imin, blk, alm};
    exp = {m_st[2:0], m_en, m_fwd, m_rt, m_is, m_im, m_bl, m_al};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got st=%0d en=%b fwd=%b rt=%b isec=%b imin=%b blank=%b alarm=%b want st=%0d en=%b fwd=%b rt=%b isec=%b imin=%b blank=%b alarm=%b",
               $time, st, en, fwd, rt, isec, imin, blk, alm,
               m_st, m_en, m_fwd, m_rt, m_is, m_im, m_bl, m_al);
    end
    if (isec) n_sec++;
  end

  // ------------------------------------------------------ directed ----
  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic press(bit [4:0] mask, bit bounce, int hold, int gap);
    if (bounce) begin
      btn = mask; step(2); btn = '0; step(2);
    end
    btn = mask; step(hold);
    btn = '0;   step(gap);
  endtask

  initial begin
    int s0;
    rst = 1'b1; step(3); rst = 1'b0;
    check("reset_state", st, 0);
    check("reset_outs", {en, fwd, rt, isec, imin, blk, alm}, 0);
    step(2);

    // bouncing inc_sec -> one pulse, IDLE->SET
    s0 = n_sec;
    btn[3] = 1; step(2); btn[3] = 0; step(2); btn[3] = 1; step(10); btn[3] = 0; step(8);
    check("bounce_one_pulse", n_sec - s0, 1);
    check("bounce_to_set", st, SET);

    // start from SET with time nonzero -> RUN counting down
    tiz = 0; btn[0] = 1; step(6);
    check("start_latency_pre", st, SET);
    step(1);
    check("start_run", st, RUN);
    check("start_fwd0", fwd, 0);
    btn[0] = 0;
    step(9);
    check("strobe_pre", en, 0);
    btn[1] = 1;                    // stop timed so PAUSE comes after 6 counts
    step(1);
    check("strobe_10th", en, 1);
    step(5);
    check("stop_pre", st, RUN);
    step(1);
    check("stop_pause", st, PAUSE);
    btn[1] = 0; step(3);
    btn[0] = 1; step(7);
    check("resume_run", st, RUN);
    btn[0] = 0;
    step(3);
    check("resume_strobe_pre", en, 0);
    step(1);
    check("resume_strobe_4", en, 1);

    // asynchronous reset mid-run
    step(2);
    rst = 1'b1; #1;
    check("async_rst_state", st, 0);
    check("async_rst_outs", {en, fwd, rt, isec, imin, blk, alm}, 0);
    step(1); rst = 1'b0; step(2);

    // start from IDLE at 00:00 -> count up
    tiz = 1; btn[0] = 1; step(7);
    check("idle_start_run", st, RUN);
    check("idle_start_fwd1", fwd, 1);
    btn[0] = 0; tiz = 0;

    // stop and finish together -> DONE wins
    btn[1] = 1; step(6);
    fin = 1; step(1);
    check("finish_beats_stop", st, DONE);
    check("done_alarm", alm, 1);
    fin = 0; btn[1] = 0;
    step(9);
    check("blank_pre", blk, 0);
    step(1);
    check("blank_on", blk, 1);
    step(10);
    check("blank_off", blk, 0);
    btn[2] = 1; step(7);
    check("done_delete_idle", st, IDLE);
    check("done_delete_rt", rt, 1);
    btn[2] = 0; step(1);
    check("rt_one_cycle", rt, 0);
    step(10);

    // randomized traffic
    for (int it = 0; it < 160; it++) begin
      bit [4:0] m;
      int sel;
      sel = $urandom_range(0, 9);
      m = (sel < 3) ? 5'b00001 : (5'b00001 << $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) m = m | (5'b00001 << $urandom_range(0, 4));
      tiz = $urandom_range(0, 1);
      fin = ($urandom_range(0, 9) == 0);
      press(m, $urandom_range(0, 2) == 0, $urandom_range(2, 14), $urandom_range(6, 20));
    end
    fin = 0; step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
